// File: rtl/eep_arb_if.sv
// eep_arb_if: command/loop request-grant-done handshake bundle for eep_arb
// master = requester side (command interface and control loop), slave = eep_arb.
// cmd_*: request, write enable, address, write data, grant and done pulses.
// loop_*: read-only request, address, grant and done pulses. rd_data: shared read result.
interface eep_arb_if;
  logic        cmd_req;
  logic        cmd_we;
  logic [1:0]  cmd_addr;
  logic [13:0] cmd_wdata;
  logic        cmd_gnt;
  logic        cmd_done;
  logic        loop_req;
  logic [1:0]  loop_addr;
  logic        loop_gnt;
  logic        loop_done;
  logic [13:0] rd_data;
  modport master(
    output cmd_req, cmd_we, cmd_addr, cmd_wdata, loop_req, loop_addr,
    input  cmd_gnt, cmd_done, loop_gnt, loop_done, rd_data
  );
  modport slave(
    input  cmd_req, cmd_we, cmd_addr, cmd_wdata, loop_req, loop_addr,
    output cmd_gnt, cmd_done, loop_gnt, loop_done, rd_data
  );
endinterface

// File: rtl/eep_arb.sv
// eep_arb: EEPROM coefficient boot loader and round-robin command/loop access arbiter
// Ports: clk, rst (asynchronous, active-high); bus = eep_arb_if.slave handshake incl. rd_data;
//   coef_wr_en/coef_sel/coef_data = datapath coefficient load; boot_done, wr_err = status;
//   eep_addr/eep_wdata/eep_rd_data/eep_cs_n/eep_r_w_n/chrg_pmp_en = EEPROM pins.
// Optional feature macro EEP_WR_VERIFY_EN: read-back verify after each write, drives sticky wr_err.
// Every output is a registered decode of the current state, so pins lag the state by one cycle.
module eep_arb #(
  parameter int CHRG_CYCLES = 1500000
) (
  input  logic        clk,
  input  logic        rst,
  eep_arb_if.slave    bus,
  output logic        coef_wr_en,
  output logic [1:0]  coef_sel,
  output logic [13:0] coef_data,
  output logic        boot_done,
  output logic        wr_err,
  output logic [1:0]  eep_addr,
  output logic [13:0] eep_wdata,
  input  logic [13:0] eep_rd_data,
  output logic        eep_cs_n,
  output logic        eep_r_w_n,
  output logic        chrg_pmp_en
);
  localparam int W = $clog2(CHRG_CYCLES);
  typedef enum logic [2:0] {
    BOOT_RD, BOOT_LD, IDLE, RD, RD_CAP, WR_CHRG,
`ifdef EEP_WR_VERIFY_EN
    WR_VFY,
`endif
    DONE
  } state_t;
`ifdef EEP_WR_VERIFY_EN
  localparam state_t WR_NEXT = WR_VFY;
`else
  localparam state_t WR_NEXT = DONE;
`endif
  state_t state, state_d;
  logic [1:0] boot_addr, boot_addr_d, op_addr, op_addr_d;
  logic [W-1:0] cnt, cnt_d;
  logic [13:0] op_wdata, op_wdata_d, rd_data, rd_data_d, coef_data_d, eep_wdata_d;
  logic [1:0] coef_sel_d, eep_addr_d;
  logic op_loop, op_loop_d, op_we, op_we_d, last_loop, last_loop_d, pick_cmd;
  logic cmd_gnt, cmd_gnt_d, loop_gnt, loop_gnt_d, cmd_done, cmd_done_d, loop_done, loop_done_d;
  logic coef_wr_en_d, boot_done_d, wr_err_d, eep_cs_n_d, eep_r_w_n_d, chrg_pmp_en_d;
  assign bus.cmd_gnt = cmd_gnt;
  assign bus.loop_gnt = loop_gnt;
  assign bus.cmd_done = cmd_done;
  assign bus.loop_done = loop_done;
  assign bus.rd_data = rd_data;
  // Tie goes to whoever was not granted last; last_loop resets high so command wins first.
  assign pick_cmd = bus.cmd_req && (!bus.loop_req || last_loop);
  always_comb begin
    state_d = state;
    boot_addr_d = boot_addr;
    cnt_d = cnt;
    op_loop_d = op_loop;
    op_we_d = op_we;
    op_addr_d = op_addr;
    op_wdata_d = op_wdata;
    last_loop_d = last_loop;
    cmd_gnt_d = 1'b0;
    loop_gnt_d = 1'b0;
    cmd_done_d = 1'b0;
    loop_done_d = 1'b0;
    rd_data_d = rd_data;
    coef_wr_en_d = 1'b0;
    coef_sel_d = coef_sel;
    coef_data_d = coef_data;
    boot_done_d = boot_done;
    wr_err_d = wr_err;
    eep_addr_d = eep_addr;
    eep_wdata_d = eep_wdata;
    eep_cs_n_d = 1'b1;
    eep_r_w_n_d = 1'b1;
    chrg_pmp_en_d = 1'b0;
    case (state)
      BOOT_RD: begin
        eep_cs_n_d = 1'b0;
        eep_addr_d = boot_addr;
        state_d = BOOT_LD;
      end
      BOOT_LD: begin
        coef_wr_en_d = 1'b1;
        coef_sel_d = boot_addr;
        coef_data_d = eep_rd_data;
        boot_addr_d = boot_addr + 2'd1;
        boot_done_d = boot_addr == 2'd3;
        state_d = (boot_addr == 2'd3) ? IDLE : BOOT_RD;
      end
      IDLE: if (bus.cmd_req || bus.loop_req) begin
        op_loop_d = !pick_cmd;
        last_loop_d = !pick_cmd;
        op_we_d = pick_cmd && bus.cmd_we;
        op_addr_d = pick_cmd ? bus.cmd_addr : bus.loop_addr;
        op_wdata_d = bus.cmd_wdata;
        cnt_d = W'(CHRG_CYCLES - 1);
        cmd_gnt_d = pick_cmd;
        loop_gnt_d = !pick_cmd;
        state_d = (pick_cmd && bus.cmd_we) ? WR_CHRG : RD;
      end
      RD: begin
        eep_cs_n_d = 1'b0;
        eep_addr_d = op_addr;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        // Also reached by the write read-back, which must not disturb rd_data or signal done.
`ifdef EEP_WR_VERIFY_EN
        wr_err_d = wr_err | (op_we && eep_rd_data != op_wdata);
`endif
        rd_data_d = op_we ? rd_data : eep_rd_data;
        cmd_done_d = !op_we && !op_loop;
        loop_done_d = !op_we && op_loop;
        state_d = DONE;
      end
      WR_CHRG: begin
        eep_cs_n_d = 1'b0;
        eep_r_w_n_d = 1'b0;
        chrg_pmp_en_d = 1'b1;
        eep_addr_d = op_addr;
        eep_wdata_d = op_wdata;
        cnt_d = cnt - W'(1);
        state_d = (cnt == '0) ? WR_NEXT : WR_CHRG;
      end
`ifdef EEP_WR_VERIFY_EN
      WR_VFY: begin
        eep_cs_n_d = 1'b0;
        eep_addr_d = op_addr;
        state_d = RD_CAP;
      end
`endif
      DONE: begin
        // Writes finish here so the coefficient mirror and done follow the charge phase.
        coef_wr_en_d = op_we;
        coef_sel_d = op_we ? op_addr : coef_sel;
        coef_data_d = op_we ? op_wdata : coef_data;
        cmd_done_d = op_we;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT_RD;
      boot_addr <= '0;
      cnt <= '0;
      op_loop <= 1'b0;
      op_we <= 1'b0;
      op_addr <= '0;
      op_wdata <= '0;
      last_loop <= 1'b1;
      cmd_gnt <= 1'b0;
      loop_gnt <= 1'b0;
      cmd_done <= 1'b0;
      loop_done <= 1'b0;
      rd_data <= '0;
      coef_wr_en <= 1'b0;
      coef_sel <= '0;
      coef_data <= '0;
      boot_done <= 1'b0;
      wr_err <= 1'b0;
      eep_addr <= '0;
      eep_wdata <= '0;
      eep_cs_n <= 1'b1;
      eep_r_w_n <= 1'b1;
      chrg_pmp_en <= 1'b0;
    end else begin
      state <= state_d;
      boot_addr <= boot_addr_d;
      cnt <= cnt_d;
      op_loop <= op_loop_d;
      op_we <= op_we_d;
      op_addr <= op_addr_d;
      op_wdata <= op_wdata_d;
      last_loop <= last_loop_d;
      cmd_gnt <= cmd_gnt_d;
      loop_gnt <= loop_gnt_d;
      cmd_done <= cmd_done_d;
      loop_done <= loop_done_d;
      rd_data <= rd_data_d;
      coef_wr_en <= coef_wr_en_d;
      coef_sel <= coef_sel_d;
      coef_data <= coef_data_d;
      boot_done <= boot_done_d;
      wr_err <= wr_err_d;
      eep_addr <= eep_addr_d;
      eep_wdata <= eep_wdata_d;
      eep_cs_n <= eep_cs_n_d;
      eep_r_w_n <= eep_r_w_n_d;
      chrg_pmp_en <= chrg_pmp_en_d;
    end
  end
endmodule

// File: tb/tb_eep_arb.sv
// tb_eep_arb: scoreboard bench for eep_arb with a behavioural EEPROM model
module tb_eep_arb;
  localparam int C = 8;
`ifdef EEP_WR_VERIFY_EN
  localparam int VFY = 2;
  localparam logic EXP_ERR = 1'b1;
`else
  localparam int VFY = 0;
  localparam logic EXP_ERR = 1'b0;
`endif
  typedef struct {logic lp; int cyc;} gnt_t;
  typedef struct {logic lp; logic rd; logic [13:0] data; int cyc;} done_t;
  typedef struct {logic [1:0] sel; logic [13:0] data; int cyc;} coef_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coef_wr_en, boot_done, wr_err, eep_cs_n, eep_r_w_n, chrg_pmp_en;
  logic [1:0] coef_sel, eep_addr;
  logic [13:0] coef_data, eep_wdata, eep_rd_data;
  logic [13:0] mem [4] = '{14'h0123, 14'h0456, 14'h0789, 14'h0ABC};
  logic corrupt = 1'b0;
  int run = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int chrg_cnt = 0;
  int coef_seen = 0;
  int rel;
  gnt_t qg[$];
  done_t qd[$];
  coef_t qc[$];
  gnt_t mg;
  done_t md;
  coef_t mc;
  eep_arb_if bus();
  eep_arb #(.CHRG_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .coef_wr_en(coef_wr_en), .coef_sel(coef_sel), .coef_data(coef_data),
    .boot_done(boot_done), .wr_err(wr_err),
    .eep_addr(eep_addr), .eep_wdata(eep_wdata), .eep_rd_data(eep_rd_data),
    .eep_cs_n(eep_cs_n), .eep_r_w_n(eep_r_w_n), .chrg_pmp_en(chrg_pmp_en)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // EEPROM: combinational read while selected; a write commits only after a full C-cycle charge.
  assign eep_rd_data = (!eep_cs_n && eep_r_w_n) ? (mem[eep_addr] ^ {13'd0, corrupt}) : 14'd0;
  always @(posedge clk) begin
    run <= (chrg_pmp_en && !eep_cs_n && !eep_r_w_n) ? run + 1 : 0;
    if (chrg_pmp_en && !eep_cs_n && !eep_r_w_n && run == C - 1) mem[eep_addr] <= eep_wdata;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push_g(input logic lp, input int c);
    gnt_t g;
    g.lp = lp;
    g.cyc = c;
    qg.push_back(g);
  endtask
  task automatic push_d(input logic lp, input logic rd, input logic [13:0] data, input int c);
    done_t d;
    d.lp = lp;
    d.rd = rd;
    d.data = data;
    d.cyc = c;
    qd.push_back(d);
  endtask
  task automatic push_c(input logic [1:0] sel, input logic [13:0] data, input int c);
    coef_t k;
    k.sel = sel;
    k.data = data;
    k.cyc = c;
    qc.push_back(k);
  endtask
  // Monitor: pops and compares whenever the DUT presents a grant, done or coefficient load.
  always @(negedge clk) begin
    if (rst) chrg_cnt = 0;
    else begin
      if (bus.cmd_gnt || bus.loop_gnt) begin
        chrg_cnt = 0;
        chk("gnt_single", {31'd0, bus.cmd_gnt & bus.loop_gnt}, 0);
        if (qg.size() == 0) chk("gnt_unexpected", {31'd0, bus.loop_gnt}, {31'd0, ~bus.loop_gnt});
        else begin
          mg = qg.pop_front();
          chk("gnt_who", {31'd0, bus.loop_gnt}, {31'd0, mg.lp});
          chk("gnt_cyc", cyc, mg.cyc);
        end
      end
      if (chrg_pmp_en) chrg_cnt++;
      if (bus.cmd_done || bus.loop_done) begin
        if (qd.size() == 0) chk("done_unexpected", {31'd0, bus.loop_done}, {31'd0, ~bus.loop_done});
        else begin
          md = qd.pop_front();
          chk("done_who", {31'd0, bus.loop_done}, {31'd0, md.lp});
          chk("done_cyc", cyc, md.cyc);
          if (md.rd) chk("rd_data", {18'd0, bus.rd_data}, {18'd0, md.data});
        end
      end
      if (coef_wr_en) begin
        coef_seen++;
        if (qc.size() == 0) chk("coef_unexpected", {30'd0, coef_sel}, {30'd0, ~coef_sel});
        else begin
          mc = qc.pop_front();
          chk("coef_sel", {30'd0, coef_sel}, {30'd0, mc.sel});
          chk("coef_data", {18'd0, coef_data}, {18'd0, mc.data});
          chk("coef_cyc", cyc, mc.cyc);
        end
      end
    end
  end
  // Called at a negedge: waits (bounded) for this requester's done, drops req, moves to the next cycle.
  task automatic wait_done(input logic lp);
    int n;
    n = 0;
    while (!(lp ? bus.loop_done : bus.cmd_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk(lp ? "loop_done_timeout" : "cmd_done_timeout", n, 0);
    if (lp) bus.loop_req = 1'b0;
    else bus.cmd_req = 1'b0;
    @(negedge clk);
  endtask
  // Issued at a negedge with the arbiter idle: grant lands next cycle.
  task automatic txn(input logic lp, input logic we, input logic [1:0] a, input logic [13:0] wd,
                     input logic [13:0] rd);
    int c, dc, cs0;
    c = cyc;
    cs0 = coef_seen;
    dc = we ? c + C + 2 + VFY : c + 3;
    if (lp) begin
      bus.loop_req = 1'b1;
      bus.loop_addr = a;
    end else begin
      bus.cmd_req = 1'b1;
      bus.cmd_we = we;
      bus.cmd_addr = a;
      bus.cmd_wdata = wd;
    end
    push_g(lp, c + 1);
    push_d(lp, !we, rd, dc);
    if (we) push_c(a, wd, dc);
    wait_done(lp);
    chk("coef_pulses", coef_seen - cs0, we ? 1 : 0);
    if (we) chk("chrg_len", chrg_cnt, C);
  endtask
  // Releases reset at a negedge (counted as boot cycle 0) and expects the four coefficient loads.
  task automatic boot(input logic [13:0] v0, input logic [13:0] v1, input logic [13:0] v2,
                      input logic [13:0] v3);
    rst = 1'b0;
    rel = cyc;
    push_c(2'd0, v0, rel + 2);
    push_c(2'd1, v1, rel + 4);
    push_c(2'd2, v2, rel + 6);
    push_c(2'd3, v3, rel + 8);
    repeat (7) @(negedge clk);
    chk("boot_done_early", {31'd0, boot_done}, 0);
    @(negedge clk);
    chk("boot_done", {31'd0, boot_done}, 1);
  endtask
  initial begin
    int c;
    bus.cmd_req = 1'b0;
    bus.cmd_we = 1'b0;
    bus.cmd_addr = 2'd0;
    bus.cmd_wdata = 14'd0;
    bus.loop_req = 1'b0;
    bus.loop_addr = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, eep_cs_n}, 1);
    chk("rst_r_w_n", {31'd0, eep_r_w_n}, 1);
    chk("rst_chrg", {31'd0, chrg_pmp_en}, 0);
    chk("rst_addr_wdata", {16'd0, eep_addr, eep_wdata}, 0);
    chk("rst_rd_data", {18'd0, bus.rd_data}, 0);
    chk("rst_coef", {15'd0, coef_wr_en, coef_sel, coef_data}, 0);
    chk("rst_status", {30'd0, boot_done, wr_err}, 0);
    chk("rst_pulses", {28'd0, bus.cmd_gnt, bus.cmd_done, bus.loop_gnt, bus.loop_done}, 0);
    // Command read held through boot: no grant until boot_done, then granted first.
    bus.cmd_req = 1'b1;
    bus.cmd_addr = 2'd3;
    boot(14'h0123, 14'h0456, 14'h0789, 14'h0ABC);
    push_g(1'b0, rel + 9);
    push_d(1'b0, 1'b1, 14'h0ABC, rel + 11);
    wait_done(1'b0);
    txn(1'b1, 1'b0, 2'd2, 14'd0, 14'h0789);
    txn(1'b0, 1'b1, 2'd1, 14'h1FFF, 14'd0);
    txn(1'b0, 1'b0, 2'd1, 14'd0, 14'h1FFF);
    txn(1'b1, 1'b0, 2'd0, 14'd0, 14'h0123);
    // Both requesters held: cmd, loop, cmd, loop, each read taking 4 cycles gnt-to-gnt.
    c = cyc;
    bus.cmd_req = 1'b1;
    bus.cmd_we = 1'b0;
    bus.cmd_addr = 2'd0;
    bus.loop_req = 1'b1;
    bus.loop_addr = 2'd2;
    push_g(1'b0, c + 1);
    push_d(1'b0, 1'b1, 14'h0123, c + 3);
    push_g(1'b1, c + 5);
    push_d(1'b1, 1'b1, 14'h0789, c + 7);
    push_g(1'b0, c + 9);
    push_d(1'b0, 1'b1, 14'h0123, c + 11);
    push_g(1'b1, c + 13);
    push_d(1'b1, 1'b1, 14'h0789, c + 15);
    repeat (11) @(negedge clk);
    bus.cmd_req = 1'b0;
    repeat (4) @(negedge clk);
    bus.loop_req = 1'b0;
    @(negedge clk);
    // Corrupted read-back trips wr_err only when the verify read exists; it must then stick.
    corrupt = 1'b1;
    txn(1'b0, 1'b1, 2'd3, 14'h0222, 14'd0);
    corrupt = 1'b0;
    chk("wr_err_set", {31'd0, wr_err}, {31'd0, EXP_ERR});
    txn(1'b0, 1'b1, 2'd3, 14'h0333, 14'd0);
    chk("wr_err_sticky", {31'd0, wr_err}, {31'd0, EXP_ERR});
    txn(1'b1, 1'b0, 2'd3, 14'd0, 14'h0333);
    // Reset in the third cycle of a write: pins drop at once, EEPROM keeps the old value.
    c = cyc;
    bus.cmd_req = 1'b1;
    bus.cmd_we = 1'b1;
    bus.cmd_addr = 2'd0;
    bus.cmd_wdata = 14'h0555;
    push_g(1'b0, c + 1);
    repeat (3) @(negedge clk);
    chk("mid_chrg_on", {31'd0, chrg_pmp_en}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_chrg", {31'd0, chrg_pmp_en}, 0);
    chk("mid_rst_cs_n", {31'd0, eep_cs_n}, 1);
    chk("mid_rst_rd_data", {18'd0, bus.rd_data}, 0);
    chk("mid_rst_status", {30'd0, boot_done, wr_err}, 0);
    bus.cmd_req = 1'b0;
    repeat (2) @(negedge clk);
    boot(14'h0123, 14'h1FFF, 14'h0789, 14'h0333);
    repeat (4) @(negedge clk);
    chk("qg_empty", qg.size(), 0);
    chk("qd_empty", qd.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
